// File: rtl/waveform_buffer.sv
// Single-frame waveform store: captures one DMA frame into block RAM and replays it
// as an AXI-stream at one word per cycle, with rewind (replay again) and clear (discard).
module waveform_buffer #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic              rewind,
  input  logic              clear,
  output logic [ADDR_W:0]   frame_len,
  output logic              loaded,
  output logic              done
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_idx;
  logic              wr_ready;
  logic              fetch_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] rd_addr_p0;
  logic [DATA_W-1:0] rd_data_p1;
  logic              wr_hs;
  logic              rd_hs;
  logic              frame_end;
  logic              last_word;

  assign wr_hs     = s_axis_tvalid & wr_ready;
  assign rd_hs     = vld_p1 & m_axis_tready;
  assign frame_end = s_axis_tlast | (wr_ptr == LAST_ADDR);
  assign last_word = ({1'b0, rd_idx} == (frame_len - LEN_ONE));

  // Lookahead address keeps the registered RAM output aligned with rd_idx after a handshake.
  always_comb begin
    rd_addr_p0 = rd_idx;
    if ((state == ST_ARMED) && rd_hs) rd_addr_p0 = rd_idx + ADDR_ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_hs && !clear) mem[wr_ptr] <= s_axis_tdata;
  end

  // ---- p0 -> p1: synchronous RAM read ----
  always_ff @(posedge clk) begin
    rd_data_p1 <= mem[rd_addr_p0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_LOAD;
      wr_ptr    <= '0;
      rd_idx    <= '0;
      frame_len <= '0;
      loaded    <= 1'b0;
      done      <= 1'b0;
      wr_ready  <= 1'b0;
      fetch_p0  <= 1'b0;
      vld_p1    <= 1'b0;
    end else if (clear) begin
      state     <= ST_LOAD;
      wr_ptr    <= '0;
      rd_idx    <= '0;
      frame_len <= '0;
      loaded    <= 1'b0;
      done      <= 1'b0;
      wr_ready  <= 1'b1;
      fetch_p0  <= 1'b0;
      vld_p1    <= 1'b0;
    end else if (rewind && (state != ST_LOAD)) begin
      state    <= ST_FETCH;
      rd_idx   <= '0;
      done     <= 1'b0;
      fetch_p0 <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          wr_ready <= 1'b1;
          if (wr_hs) begin
            if (frame_end) begin
              frame_len <= {1'b0, wr_ptr} + LEN_ONE;
              loaded    <= 1'b1;
              state     <= ST_FETCH;
              wr_ready  <= 1'b0;
              fetch_p0  <= 1'b0;
            end else begin
              wr_ptr <= wr_ptr + ADDR_ONE;
            end
          end
        end
        // Two-cycle refill: first cycle issues the read, second lands it in rd_data_p1.
        ST_FETCH: begin
          if (!fetch_p0) begin
            fetch_p0 <= 1'b1;
          end else begin
            fetch_p0 <= 1'b0;
            state    <= ST_ARMED;
            vld_p1   <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (rd_hs) begin
            if (last_word) begin
              state  <= ST_DONE;
              vld_p1 <= 1'b0;
              done   <= 1'b1;
            end else begin
              rd_idx <= rd_idx + ADDR_ONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

  // ---- p1: output, forced to zero while idle so the DAC sees silence ----
  assign s_axis_tready = wr_ready;
  assign m_axis_tvalid = vld_p1;
  assign m_axis_tdata  = vld_p1 ? rd_data_p1 : '0;

endmodule

// File: tb/tb_waveform_buffer.sv
// Scoreboard bench for waveform_buffer: loaded frames are queued as expected replay words,
// and a negedge monitor compares every output handshake against the queue.
module tb_waveform_buffer;

  localparam int DATA_W = 256;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              rewind;
  logic              clear;
  logic [ADDR_W:0]   frame_len;
  logic              loaded;
  logic              done;

  int checks   = 0;
  int failures = 0;
  int rdy_mode = 1;  // 0 low, 1 high, 2 toggle, 3 random

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] frame_q[$];

  waveform_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .rewind        (rewind),
    .clear         (clear),
    .frame_len     (frame_len),
    .loaded        (loaded),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check_d(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DATA_W-1:0] d, input logic last);
    logic hs;
    int   guard;
    guard = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    forever begin
      @(negedge clk);
      hs = s_axis_tready;
      tick();
      if (hs) break;
      guard++;
      if (guard > 50) begin
        checks++;
        failures++;
        $display("FAIL write_accept actual=stalled required=accepted");
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic load_frame(input int n, input bit use_last, input bit gaps, input int base);
    logic [DATA_W-1:0] w;
    frame_q.delete();
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) tick();
      w = (base != 0) ? DATA_W'(base + i) : rand_word();
      frame_q.push_back(w);
      write_word(w, use_last && (i == n - 1));
    end
    foreach (frame_q[k]) exp_q.push_back(frame_q[k]);
  endtask

  task automatic pulse_rewind();
    foreach (frame_q[k]) exp_q.push_back(frame_q[k]);
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check_v(name, 32'(done), 32'd1);
    check_v({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      2:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  logic [DATA_W-1:0] prev_data;
  logic [DATA_W-1:0] want;
  bit                prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && m_axis_tvalid) check_d("hold_stable", m_axis_tdata, prev_data);
      if (!m_axis_tvalid) check_d("idle_zero", m_axis_tdata, '0);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%h required=none", m_axis_tdata);
        end else begin
          want = exp_q.pop_front();
          check_d("replay_word", m_axis_tdata, want);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    clear         = 1'b0;
    rewind        = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;

    // Reset values
    repeat (2) tick();
    check_v("rst_tready", 32'(s_axis_tready), 32'd0);
    check_v("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_d("rst_tdata", m_axis_tdata, '0);
    check_v("rst_len", 32'(frame_len), 32'd0);
    check_v("rst_loaded", 32'(loaded), 32'd0);
    check_v("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    check_v("post_rst_tready", 32'(s_axis_tready), 32'd1);

    // 4-word frame 0xA..0xD, consumer always ready
    rdy_mode = 1;
    load_frame(4, 1'b1, 1'b0, 'hA);
    check_v("t1_loaded", 32'(loaded), 32'd1);
    check_v("t1_len", 32'(frame_len), 32'd4);
    check_v("t1_tready_drop", 32'(s_axis_tready), 32'd0);
    tick();
    check_v("t1_fetch_tvalid", 32'(m_axis_tvalid), 32'd0);
    tick();
    check_v("t1_first_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_d("t1_first_tdata", m_axis_tdata, DATA_W'('hA));
    repeat (3) tick();
    check_d("t1_last_tdata", m_axis_tdata, DATA_W'('hD));
    check_v("t1_last_tvalid", 32'(m_axis_tvalid), 32'd1);
    tick();
    check_v("t1_done", 32'(done), 32'd1);
    check_v("t1_done_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_d("t1_done_tdata", m_axis_tdata, '0);
    check_v("t1_drain", 32'(exp_q.size()), 32'd0);

    // Rewind with toggling consumer ready
    rdy_mode = 2;
    pulse_rewind();
    check_v("rw_done_clr", 32'(done), 32'd0);
    check_v("rw_tvalid0", 32'(m_axis_tvalid), 32'd0);
    tick();
    check_v("rw_tvalid1", 32'(m_axis_tvalid), 32'd0);
    tick();
    check_v("rw_tvalid2", 32'(m_axis_tvalid), 32'd1);
    check_d("rw_word0", m_axis_tdata, frame_q[0]);
    wait_done("rw_toggle", 200);

    // Rewind again with random consumer ready
    rdy_mode = 3;
    pulse_rewind();
    wait_done("rw_random", 200);

    // Full-depth frame without tlast
    pulse_clear();
    check_v("clr_tready", 32'(s_axis_tready), 32'd1);
    check_v("clr_loaded", 32'(loaded), 32'd0);
    check_v("clr_len", 32'(frame_len), 32'd0);
    check_v("clr_done", 32'(done), 32'd0);
    load_frame(DEPTH, 1'b0, 1'b1, 0);
    check_v("full_len", 32'(frame_len), 32'(DEPTH));
    check_v("full_loaded", 32'(loaded), 32'd1);
    check_v("full_tready", 32'(s_axis_tready), 32'd0);
    repeat (3) tick();
    check_v("full_tready_held", 32'(s_axis_tready), 32'd0);
    wait_done("full_replay", 20000);

    // clear + rewind together while word 2 is presented
    pulse_clear();
    rdy_mode = 1;
    tick();
    load_frame(6, 1'b1, 1'b0, 'h100);
    repeat (4) tick();
    check_d("cr_word2", m_axis_tdata, DATA_W'('h102));
    clear  = 1'b1;
    rewind = 1'b1;
    tick();
    clear  = 1'b0;
    rewind = 1'b0;
    check_v("cr_loaded", 32'(loaded), 32'd0);
    check_v("cr_len", 32'(frame_len), 32'd0);
    check_v("cr_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_v("cr_tready", 32'(s_axis_tready), 32'd1);
    check_v("cr_done", 32'(done), 32'd0);
    check_v("cr_popped", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    tick();
    check_v("cr_idle_tvalid", 32'(m_axis_tvalid), 32'd0);

    // Reset in the middle of a load, then a fresh 2-word frame
    for (int i = 0; i < 3; i++) write_word(rand_word(), 1'b0);
    rst = 1'b1;
    tick();
    check_v("mr_tready", 32'(s_axis_tready), 32'd0);
    check_v("mr_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_v("mr_loaded", 32'(loaded), 32'd0);
    check_v("mr_len", 32'(frame_len), 32'd0);
    check_v("mr_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    check_v("mr_tready_back", 32'(s_axis_tready), 32'd1);
    rdy_mode = 3;
    load_frame(2, 1'b1, 1'b1, 0);
    check_v("mr_new_len", 32'(frame_len), 32'd2);
    wait_done("mr_replay", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
